// File: rtl/cpi_tx_gen.sv
// CPI camera-interface transmitter: frames a valid/ready pixel stream onto pclk/hsync/vsync/data.
// Latency: a frame starts on the first pclk falling edge after start_i; outputs change only on that edge.
// Backpressure: px_ready pulses once per pixel slot; a missing pixel sends 0 and flags err without stalling.
module cpi_tx_gen #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cfg_en_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [CNT_W-1:0]  cfg_width_i,
  input  logic [CNT_W-1:0]  cfg_height_i,
  input  logic [CNT_W-1:0]  cfg_vsync_i,
  input  logic [CNT_W-1:0]  cfg_vblank_i,
  input  logic [CNT_W-1:0]  cfg_hblank_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] px_data_i,
  input  logic              px_valid_i,
  output logic              px_ready_o,
  output logic              cpi_pclk_o,
  output logic              cpi_hsync_o,
  output logic              cpi_vsync_o,
  output logic [DATA_W-1:0] cpi_data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBLANK = 3'd2,
    S_LINE   = 3'd3,
    S_HBLANK = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               pclk_q, pclk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   line_q, line_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               latch;

  // configuration captured at frame start so mid-frame cfg changes are harmless
  logic [DIV_W-1:0]   div_l;
  logic [CNT_W-1:0]   width_l, height_l, vsync_l, vblank_l, hblank_l;

  logic [DIV_W-1:0]   div_sel, div_lim;
  logic [CNT_W-1:0]   vs_len, hb_len;
  logic               toggle, tick;

  // the divider follows the live setting while idle so pclk free-runs, latched value during a frame
  always_comb begin
    div_sel = (state_q == S_IDLE) ? cfg_div_i : div_l;
    div_lim = (div_sel == '0) ? DIV_W'(1) : div_sel;
    toggle  = cfg_en_i && (div_cnt_q >= div_lim - 1'b1);
    tick    = toggle && pclk_q;
    vs_len  = (vsync_l == '0) ? CNT_W'(1) : vsync_l;
    hb_len  = (hblank_l == '0) ? CNT_W'(1) : hblank_l;
  end

  assign px_ready_o   = (state_q == S_LINE) && tick;
  assign cpi_pclk_o   = pclk_q;
  assign cpi_hsync_o  = hsync_q;
  assign cpi_vsync_o  = vsync_q;
  assign cpi_data_o   = data_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = done_q;
  assign err_o        = err_q;

  // next-state, divider and pad values; pad values only move on a tick (pclk falling)
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    data_d    = data_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    latch     = 1'b0;
    div_cnt_d = div_cnt_q + 1'b1;
    pclk_d    = pclk_q;

    if (!cfg_en_i) begin
      div_cnt_d = '0;
      pclk_d    = 1'b0;
    end else if (toggle) begin
      div_cnt_d = '0;
      pclk_d    = !pclk_q;
    end

    if (!cfg_en_i) begin
      state_d = S_IDLE;
      hsync_d = 1'b0;
      vsync_d = 1'b0;
      data_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_width_i != '0 && cfg_height_i != '0) begin
              latch   = 1'b1;
              state_d = S_VSYNC;
              cnt_d   = '0;
              line_d  = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_VSYNC: begin
          if (tick) begin
            vsync_d = 1'b1;
            hsync_d = 1'b0;
            data_d  = '0;
            if (cnt_q == vs_len - 1'b1) begin
              cnt_d   = '0;
              state_d = (vblank_l == '0) ? S_LINE : S_VBLANK;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_VBLANK: begin
          if (tick) begin
            vsync_d = 1'b0;
            if (cnt_q == vblank_l - 1'b1) begin
              cnt_d   = '0;
              state_d = S_LINE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_LINE: begin
          if (tick) begin
            vsync_d = 1'b0;
            hsync_d = 1'b1;
            data_d  = px_valid_i ? px_data_i : '0;
            err_d   = !px_valid_i;
            if (cnt_q == width_l - 1'b1) begin
              cnt_d   = '0;
              line_d  = line_q + 1'b1;
              state_d = S_HBLANK;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_HBLANK: begin
          if (tick) begin
            hsync_d = 1'b0;
            data_d  = '0;
            if (cnt_q == hb_len - 1'b1) begin
              cnt_d   = '0;
              state_d = (line_q < height_l) ? S_LINE : S_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (tick) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state, divider and pad registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      pclk_q    <= 1'b0;
      cnt_q     <= '0;
      line_q    <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      pclk_q    <= pclk_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      data_q    <= data_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // frame configuration snapshot taken when a start request is accepted
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      div_l    <= '0;
      width_l  <= '0;
      height_l <= '0;
      vsync_l  <= '0;
      vblank_l <= '0;
      hblank_l <= '0;
    end else if (latch) begin
      div_l    <= cfg_div_i;
      width_l  <= cfg_width_i;
      height_l <= cfg_height_i;
      vsync_l  <= cfg_vsync_i;
      vblank_l <= cfg_vblank_i;
      hblank_l <= cfg_hblank_i;
    end
  end

endmodule
